// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus router slice.
package bus_pkg;

  localparam int unsigned BusAddrWidth         = 30;
  localparam int unsigned BusDataWidth         = 32;
  localparam int unsigned RouterTimeoutDefault = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } router_state_e;

  typedef struct packed {
    logic                        we;
    logic [BusAddrWidth-1:0]     addr;
    logic [BusDataWidth-1:0]     wdata;
    logic [BusDataWidth/8-1:0]   be;
  } bus_req_t;

endpackage

// File: rtl/bus_timeout.sv
// BUSY-cycle counter; expired_o is high during the TimeoutCycles-th enabled cycle after a clear.
module bus_timeout #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expired_q, expired_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
    // Registered compare: cnt_q counts completed BUSY cycles, so the Nth cycle sees N-1.
    expired_d = (cnt_d == CntW'(TimeoutCycles - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/bus_router.sv
// Forwards one decoded master request to a single slave and returns its ack/data,
// completing with an error on unmapped tags or slave timeout.
module bus_router
  import bus_pkg::*;
#(
  parameter int unsigned TagWidth      = 2,
  parameter int unsigned NumSlaves     = 4,
  parameter int unsigned AddrWidth     = BusAddrWidth,
  parameter int unsigned DataWidth     = BusDataWidth,
  parameter int unsigned TimeoutCycles = RouterTimeoutDefault
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           m_req_i,
  input  logic                           m_we_i,
  input  logic [AddrWidth-1:0]           m_addr_i,
  input  logic [TagWidth-1:0]            m_tag_i,
  input  logic [DataWidth-1:0]           m_wdata_i,
  input  logic [DataWidth/8-1:0]         m_be_i,
  output logic                           m_ack_o,
  output logic                           m_err_o,
  output logic [DataWidth-1:0]           m_rdata_o,
  output logic [NumSlaves-1:0]           s_req_o,
  output logic                           s_we_o,
  output logic [AddrWidth-1:0]           s_addr_o,
  output logic [DataWidth-1:0]           s_wdata_o,
  output logic [DataWidth/8-1:0]         s_be_o,
  input  logic [NumSlaves-1:0]           s_ack_i,
  input  logic [NumSlaves*DataWidth-1:0] s_rdata_i
);

  localparam int unsigned TagCmpW = TagWidth + 1;

  router_state_e          state_q, state_d;
  bus_req_t               req_q, req_d;
  logic [TagWidth-1:0]    sel_q, sel_d;
  logic [NumSlaves-1:0]   s_req_q, s_req_d;
  logic                   m_ack_q, m_ack_d;
  logic                   m_err_q, m_err_d;
  logic [DataWidth-1:0]   m_rdata_q, m_rdata_d;

  logic                   tag_mapped_c;
  logic                   ack_sel_c;
  logic                   expired_c;
  logic [DataWidth-1:0]   rdata_sel_c;

  bus_timeout #(
    .TimeoutCycles (TimeoutCycles)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == IDLE),
    .en_i      (state_q == BUSY),
    .expired_o (expired_c)
  );

  assign tag_mapped_c = ({1'b0, m_tag_i} < TagCmpW'(NumSlaves));
  // Only the selected slave's ack counts; s_req_q is one-hot while BUSY.
  assign ack_sel_c    = |(s_ack_i & s_req_q);

  always_comb begin
    rdata_sel_c = '0;
    for (int unsigned k = 0; k < NumSlaves; k++) begin
      if (sel_q == TagWidth'(k)) begin
        rdata_sel_c = s_rdata_i[k*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    sel_d     = sel_q;
    s_req_d   = s_req_q;
    m_ack_d   = 1'b0;
    m_err_d   = m_err_q;
    m_rdata_d = m_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (m_req_i) begin
          if (tag_mapped_c) begin
            sel_d       = m_tag_i;
            req_d.we    = m_we_i;
            req_d.addr  = BusAddrWidth'(m_addr_i);
            req_d.wdata = BusDataWidth'(m_wdata_i);
            req_d.be    = (BusDataWidth/8)'(m_be_i);
            s_req_d     = NumSlaves'(1) << m_tag_i;
            state_d     = BUSY;
          end else begin
            m_ack_d   = 1'b1;
            m_err_d   = 1'b1;
            m_rdata_d = '0;
            state_d   = RESP;
          end
        end
      end
      BUSY: begin
        // Ack beats a simultaneous timeout.
        if (ack_sel_c) begin
          s_req_d   = '0;
          m_ack_d   = 1'b1;
          m_err_d   = 1'b0;
          m_rdata_d = rdata_sel_c;
          state_d   = RESP;
        end else if (expired_c) begin
          s_req_d   = '0;
          m_ack_d   = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = '0;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        s_req_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      sel_q     <= '0;
      s_req_q   <= '0;
      m_ack_q   <= 1'b0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      s_req_q   <= s_req_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  assign m_ack_o   = m_ack_q;
  assign m_err_o   = m_err_q;
  assign m_rdata_o = m_rdata_q;
  assign s_req_o   = s_req_q;
  assign s_we_o    = req_q.we;
  assign s_addr_o  = AddrWidth'(req_q.addr);
  assign s_wdata_o = DataWidth'(req_q.wdata);
  assign s_be_o    = (DataWidth/8)'(req_q.be);

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: a 4-slave instance and a 3-slave instance, both with a 4-cycle timeout.
module tb_bus_router;

  logic         clk = 1'b0;
  logic         rst;

  logic         m_req, m_we;
  logic [29:0]  m_addr;
  logic [1:0]   m_tag;
  logic [31:0]  m_wdata;
  logic [3:0]   m_be;
  logic         m_ack, m_err;
  logic [31:0]  m_rdata;
  logic [3:0]   s_req;
  logic         s_we;
  logic [29:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_be;
  logic [3:0]   s_ack;
  logic [127:0] s_rdata;

  logic         m3_req;
  logic [1:0]   m3_tag;
  logic         m3_ack, m3_err;
  logic [31:0]  m3_rdata;
  logic [2:0]   s3_req;
  logic         s3_we;
  logic [29:0]  s3_addr;
  logic [31:0]  s3_wdata;
  logic [3:0]   s3_be;
  logic [2:0]   s3_ack;
  logic [95:0]  s3_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_router #(.TagWidth(2), .NumSlaves(4), .AddrWidth(30), .DataWidth(32), .TimeoutCycles(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_tag_i(m_tag),
    .m_wdata_i(m_wdata), .m_be_i(m_be),
    .m_ack_o(m_ack), .m_err_o(m_err), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_be_o(s_be),
    .s_ack_i(s_ack), .s_rdata_i(s_rdata)
  );

  bus_router #(.TagWidth(2), .NumSlaves(3), .AddrWidth(30), .DataWidth(32), .TimeoutCycles(4)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m3_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_tag_i(m3_tag),
    .m_wdata_i(m_wdata), .m_be_i(m_be),
    .m_ack_o(m3_ack), .m_err_o(m3_err), .m_rdata_o(m3_rdata),
    .s_req_o(s3_req), .s_we_o(s3_we), .s_addr_o(s3_addr), .s_wdata_o(s3_wdata), .s_be_o(s3_be),
    .s_ack_i(s3_ack), .s_rdata_i(s3_rdata)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1;
    m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_tag = '0; m_wdata = '0; m_be = '0;
    s_ack = '0; s_rdata = '0;
    m3_req = 1'b0; m3_tag = '0; s3_ack = '0; s3_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_s_req",  64'(s_req),  64'h0);
    check("rst_m_ack",  64'(m_ack),  64'h0);
    check("rst_m_err",  64'(m_err),  64'h0);
    check("rst_rdata",  64'(m_rdata), 64'h0);
    check("rst_s_addr", 64'(s_addr), 64'h0);

    // Read tag 2, slave acks in cycle 3.
    m_req = 1'b1; m_we = 1'b0; m_tag = 2'd2; m_addr = 30'h0000_0100;
    tick();
    check("rd_c1_s_req", 64'(s_req), 64'h4);
    check("rd_c1_addr",  64'(s_addr), 64'h100);
    check("rd_c1_we",    64'(s_we), 64'h0);
    tick();
    check("rd_c2_s_req", 64'(s_req), 64'h4);
    check("rd_c2_m_ack", 64'(m_ack), 64'h0);
    tick();
    check("rd_c3_s_req", 64'(s_req), 64'h4);
    s_ack = 4'b0100; s_rdata[2*32 +: 32] = 32'hDEAD_BEEF;
    tick();
    s_ack = '0; m_req = 1'b0;
    check("rd_c4_m_ack", 64'(m_ack), 64'h1);
    check("rd_c4_err",   64'(m_err), 64'h0);
    check("rd_c4_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
    check("rd_c4_s_req", 64'(s_req), 64'h0);
    tick();
    check("rd_c5_m_ack", 64'(m_ack), 64'h0);
    check("rd_c5_hold",  64'(m_rdata), 64'hDEAD_BEEF);

    // Write tag 0, combinational ack in cycle 1.
    m_req = 1'b1; m_we = 1'b1; m_tag = 2'd0; m_addr = 30'h0000_0040;
    m_wdata = 32'h1234_5678; m_be = 4'b0011;
    tick();
    check("wr_c1_s_req", 64'(s_req), 64'h1);
    check("wr_c1_we",    64'(s_we), 64'h1);
    check("wr_c1_wdata", 64'(s_wdata), 64'h1234_5678);
    check("wr_c1_be",    64'(s_be), 64'h3);
    check("wr_c1_m_ack", 64'(m_ack), 64'h0);
    s_ack = 4'b0001; s_rdata[0 +: 32] = 32'hAAAA_5555;
    tick();
    s_ack = '0; m_req = 1'b0;
    check("wr_c2_m_ack", 64'(m_ack), 64'h1);
    check("wr_c2_err",   64'(m_err), 64'h0);
    check("wr_c2_rdata", 64'(m_rdata), 64'hAAAA_5555);
    tick();

    // Three-slave instance: mapped read first, then unmapped tag 3.
    m_we = 1'b0;
    m3_req = 1'b1; m3_tag = 2'd1;
    tick();
    check("n3_c1_s_req", 64'(s3_req), 64'h2);
    s3_ack = 3'b010; s3_rdata[1*32 +: 32] = 32'h5A5A_5A5A;
    tick();
    s3_ack = '0; m3_req = 1'b0;
    check("n3_rd_ack",   64'(m3_ack), 64'h1);
    check("n3_rd_rdata", 64'(m3_rdata), 64'h5A5A_5A5A);
    tick();
    m3_req = 1'b1; m3_tag = 2'd3;
    tick();
    m3_req = 1'b0;
    check("unm_c1_ack",   64'(m3_ack), 64'h1);
    check("unm_c1_err",   64'(m3_err), 64'h1);
    check("unm_c1_rdata", 64'(m3_rdata), 64'h0);
    check("unm_c1_s_req", 64'(s3_req), 64'h0);
    tick();
    check("unm_c2_ack",   64'(m3_ack), 64'h0);
    check("unm_c2_s_req", 64'(s3_req), 64'h0);

    // Timeout: slave 1 never acks, four BUSY cycles.
    m_req = 1'b1; m_tag = 2'd1; m_addr = 30'h0000_0200;
    tick();
    check("to_c1_s_req", 64'(s_req), 64'h2);
    tick(); tick(); tick();
    check("to_c4_s_req", 64'(s_req), 64'h2);
    check("to_c4_m_ack", 64'(m_ack), 64'h0);
    tick();
    m_req = 1'b0;
    check("to_c5_s_req", 64'(s_req), 64'h0);
    check("to_c5_m_ack", 64'(m_ack), 64'h1);
    check("to_c5_err",   64'(m_err), 64'h1);
    check("to_c5_rdata", 64'(m_rdata), 64'h0);
    tick();

    // Ack on the expiry cycle wins over the timeout.
    m_req = 1'b1; m_tag = 2'd1;
    tick(); tick(); tick(); tick();
    check("toa_c4_s_req", 64'(s_req), 64'h2);
    s_ack = 4'b0010; s_rdata[1*32 +: 32] = 32'hCAFE_0001;
    tick();
    s_ack = '0; m_req = 1'b0;
    check("toa_c5_m_ack", 64'(m_ack), 64'h1);
    check("toa_c5_err",   64'(m_err), 64'h0);
    check("toa_c5_rdata", 64'(m_rdata), 64'hCAFE_0001);
    tick();

    // Spurious ack from slave 3 while slave 1 is selected.
    m_req = 1'b1; m_tag = 2'd1;
    tick();
    s_ack = 4'b1000; s_rdata[3*32 +: 32] = 32'h3333_3333;
    tick();
    check("sp_c2_m_ack", 64'(m_ack), 64'h0);
    check("sp_c2_s_req", 64'(s_req), 64'h2);
    s_ack = 4'b0010; s_rdata[1*32 +: 32] = 32'h1111_1111;
    tick();
    m_req = 1'b0;
    check("sp_c3_m_ack", 64'(m_ack), 64'h1);
    check("sp_c3_err",   64'(m_err), 64'h0);
    check("sp_c3_rdata", 64'(m_rdata), 64'h1111_1111);
    tick();
    s_ack = '0;
    check("sp_c4_late_ack", 64'(m_ack), 64'h0);
    check("sp_c4_s_req",    64'(s_req), 64'h0);
    tick();

    // Reset in the middle of BUSY aborts without an ack.
    m_req = 1'b1; m_we = 1'b1; m_tag = 2'd2; m_addr = 30'h0000_0300;
    tick();
    check("rb_c1_s_req", 64'(s_req), 64'h4);
    rst = 1'b1; m_req = 1'b0;
    tick();
    rst = 1'b0;
    check("rb_s_req",  64'(s_req), 64'h0);
    check("rb_m_ack",  64'(m_ack), 64'h0);
    check("rb_rdata",  64'(m_rdata), 64'h0);
    check("rb_s_addr", 64'(s_addr), 64'h0);
    check("rb_s_we",   64'(s_we), 64'h0);
    tick();
    check("rb_c2_m_ack", 64'(m_ack), 64'h0);
    tick();
    check("rb_c3_m_ack", 64'(m_ack), 64'h0);

    // Back-to-back: tag 0 then tag 1, second accepted in the IDLE cycle after the ack.
    m_req = 1'b1; m_we = 1'b0; m_tag = 2'd0; m_addr = 30'h0000_0010;
    tick();
    check("bb_c1_s_req", 64'(s_req), 64'h1);
    s_ack = 4'b0001; s_rdata[0 +: 32] = 32'h0000_0A0A;
    tick();
    s_ack = '0;
    check("bb_c2_m_ack", 64'(m_ack), 64'h1);
    check("bb_c2_rdata", 64'(m_rdata), 64'h0000_0A0A);
    m_tag = 2'd1; m_addr = 30'h0000_0020;
    tick();
    check("bb_c3_m_ack", 64'(m_ack), 64'h0);
    check("bb_c3_s_req", 64'(s_req), 64'h0);
    tick();
    check("bb_c4_s_req", 64'(s_req), 64'h2);
    check("bb_c4_addr",  64'(s_addr), 64'h20);
    s_ack = 4'b0010; s_rdata[1*32 +: 32] = 32'h0000_0B0B;
    tick();
    s_ack = '0; m_req = 1'b0;
    check("bb_c5_m_ack", 64'(m_ack), 64'h1);
    check("bb_c5_rdata", 64'(m_rdata), 64'h0000_0B0B);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
